// File: rtl/param_mod_counter_pkg.sv
// Shared constants, operation encoding and priority helper for the modulo counter.
package param_mod_counter_pkg;

  localparam logic CNT_UP   = 1'b1;
  localparam logic CNT_DOWN = 1'b0;
  localparam int   CNT_WRAP = 0;
  localparam int   CNT_SAT  = 1;

  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_STEP = 2'd1,
    OP_LOAD = 2'd2,
    OP_CLR  = 2'd3
  } cnt_op_t;

  // clr beats load beats a step; nothing asserted means hold.
  function automatic cnt_op_t sel_op(input logic clr, input logic load, input logic step);
    if (clr)       return OP_CLR;
    else if (load) return OP_LOAD;
    else if (step) return OP_STEP;
    else           return OP_HOLD;
  endfunction

endpackage

// File: rtl/param_mod_counter_next_logic.sv
// Step datapath: next count, terminal count and wrap for one up/down step.
// Latency: purely combinational.
// Backpressure: none; count_enable is the only qualifier.
module param_mod_counter_next_logic
  import param_mod_counter_pkg::*;
#(
  parameter int WIDTH    = 5,
  parameter int MODULUS  = 32,
  parameter int SATURATE = CNT_WRAP
) (
  input  logic [WIDTH-1:0] count,
  input  logic             up_down,
  input  logic             count_enable,
  output logic [WIDTH-1:0] next_count,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MODULUS - 1);

  logic at_max;
  logic at_min;

  assign at_max = (count == CNT_MAX);
  assign at_min = (count == '0);

  assign tc   = count_enable & (((up_down == CNT_UP) & at_max) | ((up_down == CNT_DOWN) & at_min));
  assign wrap = tc & (SATURATE == CNT_WRAP);

  always_comb begin
    next_count = count;
    if (count_enable) begin
      if (up_down == CNT_UP) begin
        if (!at_max)                  next_count = count + 1'b1;
        else if (SATURATE != CNT_SAT) next_count = '0;
      end else begin
        if (!at_min)                  next_count = count - 1'b1;
        else if (SATURATE != CNT_SAT) next_count = CNT_MAX;
      end
    end
  end

endmodule

// File: rtl/param_mod_counter.sv
// Up/down modulo counter with clear, clamped load, wrap/saturate and cascade tc.
// Latency: count and wrap_pulse registered (1 cycle); tc combinational.
// Backpressure: none; count_enable gates every step.
module param_mod_counter
  import param_mod_counter_pkg::*;
#(
  parameter int WIDTH       = 5,
  parameter int MODULUS     = 32,
  parameter int SATURATE    = CNT_WRAP,
  parameter int RESET_VALUE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             count_enable,
  input  logic             up_down,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap_pulse
);

  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] CNT_RST = WIDTH'(RESET_VALUE);

  if (MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH) ||
      RESET_VALUE < 0 || RESET_VALUE >= MODULUS) begin : g_param_check
    $fatal(1, "param_mod_counter: MODULUS or RESET_VALUE out of range");
  end

  logic [WIDTH-1:0] next_count;
  logic [WIDTH-1:0] load_clamped;
  logic             step_tc;
  logic             step_wrap;
  cnt_op_t          op;

  param_mod_counter_next_logic #(
    .WIDTH    (WIDTH),
    .MODULUS  (MODULUS),
    .SATURATE (SATURATE)
  ) u_next (
    .count        (count),
    .up_down      (up_down),
    .count_enable (count_enable),
    .next_count   (next_count),
    .tc           (step_tc),
    .wrap         (step_wrap)
  );

  // Out-of-range loads pin to the top of the range so count stays legal.
  assign load_clamped = (load_value > CNT_MAX) ? CNT_MAX : load_value;
  assign op           = sel_op(clr, load, count_enable);
  assign tc           = step_tc & ~clr & ~load;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count      <= CNT_RST;
      wrap_pulse <= 1'b0;
    end else begin
      case (op)
        OP_CLR: begin
          count      <= '0;
          wrap_pulse <= 1'b0;
        end
        OP_LOAD: begin
          count      <= load_clamped;
          wrap_pulse <= 1'b0;
        end
        OP_STEP: begin
          count      <= next_count;
          wrap_pulse <= step_wrap;
        end
        default: begin
          wrap_pulse <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_param_mod_counter.sv
// Directed bench: wrap, down-count, saturate, priority, clamp, cascade and async reset.
module tb_param_mod_counter;

  logic clk;
  logic reset;

  // instance a: 5-bit, modulus 32, wrap, reset 0
  logic       clr_a, load_a, en_a, ud_a, tc_a, wp_a;
  logic [4:0] lv_a, count_a;
  // instance b: 5-bit, modulus 10, wrap, reset 4
  logic       clr_b, load_b, en_b, ud_b, tc_b, wp_b;
  logic [4:0] lv_b, count_b;
  // instance c: 5-bit, modulus 10, saturate, reset 0
  logic       clr_c, load_c, en_c, ud_c, tc_c, wp_c;
  logic [4:0] lv_c, count_c;
  // cascade: two 4-bit modulus-10 stages
  logic       en_lo, tc_lo, wp_lo, tc_hi, wp_hi;
  logic [3:0] cnt_lo, cnt_hi;

  int checks = 0;
  int errors = 0;

  int exp_dn     [5] = '{2, 1, 0, 9, 8};
  int exp_dn_tc  [5] = '{0, 0, 0, 1, 0};
  int exp_dn_wp  [5] = '{0, 0, 0, 1, 0};
  int exp_sat    [5] = '{8, 9, 9, 9, 9};
  int exp_sat_tc [5] = '{0, 0, 1, 1, 1};

  param_mod_counter #(.WIDTH(5), .MODULUS(32), .SATURATE(0), .RESET_VALUE(0)) u_a (
    .clk(clk), .reset(reset), .clr(clr_a), .load(load_a), .load_value(lv_a),
    .count_enable(en_a), .up_down(ud_a), .count(count_a), .tc(tc_a), .wrap_pulse(wp_a));

  param_mod_counter #(.WIDTH(5), .MODULUS(10), .SATURATE(0), .RESET_VALUE(4)) u_b (
    .clk(clk), .reset(reset), .clr(clr_b), .load(load_b), .load_value(lv_b),
    .count_enable(en_b), .up_down(ud_b), .count(count_b), .tc(tc_b), .wrap_pulse(wp_b));

  param_mod_counter #(.WIDTH(5), .MODULUS(10), .SATURATE(1), .RESET_VALUE(0)) u_c (
    .clk(clk), .reset(reset), .clr(clr_c), .load(load_c), .load_value(lv_c),
    .count_enable(en_c), .up_down(ud_c), .count(count_c), .tc(tc_c), .wrap_pulse(wp_c));

  param_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .RESET_VALUE(0)) u_lo (
    .clk(clk), .reset(reset), .clr(1'b0), .load(1'b0), .load_value(4'd0),
    .count_enable(en_lo), .up_down(1'b1), .count(cnt_lo), .tc(tc_lo), .wrap_pulse(wp_lo));

  param_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .RESET_VALUE(0)) u_hi (
    .clk(clk), .reset(reset), .clr(1'b0), .load(1'b0), .load_value(4'd0),
    .count_enable(tc_lo), .up_down(1'b1), .count(cnt_hi), .tc(tc_hi), .wrap_pulse(wp_hi));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    {clr_a, load_a, en_a, ud_a} = '0; lv_a = '0;
    {clr_b, load_b, en_b, ud_b} = '0; lv_b = '0;
    {clr_c, load_c, en_c, ud_c} = '0; lv_c = '0;
    en_lo = 1'b0;
    #2;
    chk("rst_count_a", count_a, 0);
    chk("rst_wp_a", wp_a, 0);
    chk("rst_count_b", count_b, 4);
    chk("rst_count_c", count_c, 0);
    chk("rst_cnt_lo", cnt_lo, 0);
    tick();
    reset = 1'b0;
    tick();

    // full wrap of modulus 32
    en_a = 1'b1; ud_a = 1'b1;
    for (int i = 0; i < 32; i++) begin
      chk("up32_count", count_a, i);
      chk("up32_tc", tc_a, (i == 31));
      tick();
      chk("up32_wp", wp_a, (i == 31));
    end
    chk("up32_wrapped", count_a, 0);
    tick();
    chk("up32_after", count_a, 1);
    chk("up32_wp_clear", wp_a, 0);

    // clr beats load beats enable
    en_a = 1'b0; load_a = 1'b1; lv_a = 5'd5;
    tick();
    chk("load5", count_a, 5);
    clr_a = 1'b1; load_a = 1'b1; en_a = 1'b1; lv_a = 5'd17;
    tick();
    chk("clr_prio", count_a, 0);
    chk("clr_prio_wp", wp_a, 0);

    // tc gating by load/clr at a terminal value
    clr_a = 1'b0; load_a = 1'b1; en_a = 1'b0; lv_a = 5'd31;
    tick();
    chk("load31", count_a, 31);
    load_a = 1'b0; en_a = 1'b1; ud_a = 1'b1;
    #1 chk("tc_at31", tc_a, 1);
    load_a = 1'b1;
    #1 chk("tc_gate_load", tc_a, 0);
    load_a = 1'b0; clr_a = 1'b1;
    #1 chk("tc_gate_clr", tc_a, 0);
    clr_a = 1'b0;
    tick();
    chk("wrap31_count", count_a, 0);
    chk("wrap31_wp", wp_a, 1);
    en_a = 1'b0;

    // modulus 10 count down from 3
    load_b = 1'b1; lv_b = 5'd3;
    tick();
    chk("ld3_b", count_b, 3);
    load_b = 1'b0; en_b = 1'b1; ud_b = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("dn_tc", tc_b, exp_dn_tc[i]);
      tick();
      chk("dn_count", count_b, exp_dn[i]);
      chk("dn_wp", wp_b, exp_dn_wp[i]);
    end
    ud_b = 1'b1;
    tick();
    chk("dir_flip", count_b, 9);
    #1 chk("dir_flip_tc", tc_b, 1);
    en_b = 1'b0; load_b = 1'b1; lv_b = 5'd2;
    tick();
    chk("ld2_b", count_b, 2);
    lv_b = 5'd25;
    tick();
    chk("ld25_clamp", count_b, 9);
    chk("ld25_wp", wp_b, 0);
    load_b = 1'b0;

    // modulus 10 saturate up from 7
    load_c = 1'b1; lv_c = 5'd7;
    tick();
    chk("ld7_c", count_c, 7);
    load_c = 1'b0; en_c = 1'b1; ud_c = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("sat_tc", tc_c, exp_sat_tc[i]);
      tick();
      chk("sat_count", count_c, exp_sat[i]);
      chk("sat_wp", wp_c, 0);
    end
    en_c = 1'b0; load_c = 1'b1; lv_c = 5'd0;
    tick();
    load_c = 1'b0; en_c = 1'b1; ud_c = 1'b0;
    #1 chk("sat0_tc", tc_c, 1);
    tick();
    chk("sat0_hold", count_c, 0);
    chk("sat0_wp", wp_c, 0);
    en_c = 1'b0;

    // two-stage decade cascade
    en_lo = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("casc10_lo", cnt_lo, 0);
    chk("casc10_hi", cnt_hi, 1);
    for (int i = 0; i < 89; i++) tick();
    chk("casc99_lo", cnt_lo, 9);
    chk("casc99_hi", cnt_hi, 9);
    chk("casc99_tc_lo", tc_lo, 1);
    chk("casc99_tc_hi", tc_hi, 1);
    tick();
    chk("casc100_lo", cnt_lo, 0);
    chk("casc100_hi", cnt_hi, 0);
    chk("casc100_wp_hi", wp_hi, 1);
    en_lo = 1'b0;

    // asynchronous reset mid-cycle
    load_b = 1'b1; lv_b = 5'd6;
    tick();
    chk("ld6_b", count_b, 6);
    load_b = 1'b0; en_b = 1'b1; ud_b = 1'b1;
    #2 reset = 1'b1;
    #1 chk("arst_count_b", count_b, 4);
    chk("arst_wp_b", wp_b, 0);
    chk("arst_count_a", count_a, 0);
    tick();
    chk("arst_hold1", count_b, 4);
    tick();
    chk("arst_hold2", count_b, 4);
    reset = 1'b0;
    tick();
    chk("arst_release", count_b, 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
